// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the multicycle MIPS fetch sequencer.
// The ERR state and the timeout limit matter only when FETCH_TIMEOUT_EN is defined.
package mips_fetch_pkg;

    // Fetch sequencer states; ERR is reachable only with the timeout enabled.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DONE = 2'd2,
        FS_ERR  = 2'd3
    } fetch_state_e;

    // One MIPS instruction word is four bytes; PC advances by this amount.
    localparam int unsigned INSTR_BYTES = 4;

    // Default number of unanswered REQ cycles before a fetch is abandoned.
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // Counter width able to hold the value `limit` itself.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch sequencer's control, memory and PC-update signals.
// slave = the fetch unit, master = the control FSM / memory side driving it.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_start;
    logic [ADDR_W-1:0] pc_in;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [DATA_W-1:0] ir_out;
    logic [ADDR_W-1:0] pc_next;
    logic              pc_write;
    logic              fetch_done;
    logic              busy;
    logic              fetch_err;

    modport slave (
        input  fetch_start, pc_in, mem_rdata, mem_ready,
        output mem_req, mem_addr, ir_out, pc_next, pc_write, fetch_done, busy, fetch_err
    );

    modport master (
        output fetch_start, pc_in, mem_rdata, mem_ready,
        input  mem_req, mem_addr, ir_out, pc_next, pc_write, fetch_done, busy, fetch_err
    );
endinterface

// File: rtl/instruction_fetch_unit_timeout_counter.sv
// Wait counter for the fetch sequencer: counts REQ cycles without mem_ready
// and flags the cycle on which the limit is hit. Used only under FETCH_TIMEOUT_EN.
module fetch_timeout_counter
    import mips_fetch_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,   // entering REQ: start a fresh count
    input  logic wait_i,    // in REQ and memory has not answered this cycle
    output logic expire_o   // this wait cycle brings the count to LIMIT
);
    localparam int unsigned    CNT_W = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Limit is reached on the wait cycle that would make the count equal LIMIT.
    assign expire_o = wait_i && (cnt_q == LAST);

    // Next count: clear on REQ entry, otherwise advance on each unanswered cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (wait_i)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Multicycle MIPS instruction fetch sequencer.
// IDLE latches the PC, REQ holds a registered memory request until mem_ready,
// DONE emits a one-cycle pc_write/fetch_done pulse with IR and PC+4 registered.
// Optional feature macro: FETCH_TIMEOUT_EN (adds wait counter and ERR state).
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset_n,
    instruction_fetch_unit_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = FS_IDLE;
    localparam logic [1:0] ST_REQ  = FS_REQ;
    localparam logic [1:0] ST_DONE = FS_DONE;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [1:0] ST_ERR  = FS_ERR;
`endif

    // A zero limit would abandon every fetch before memory can answer.
    if (TIMEOUT_CYCLES == 0) begin : g_illegal_timeout
    end

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic              mem_req_q, mem_req_d;
    logic              done_q, done_d;
    logic              timeout_hit;
    logic              start_acc;

    // A request is accepted only from IDLE; anything arriving while busy is dropped.
    assign start_acc = (state_q == ST_IDLE) && bus.fetch_start;

`ifdef FETCH_TIMEOUT_EN
    logic err_q, err_d;

    fetch_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_i  (start_acc),
        .wait_i   ((state_q == ST_REQ) && !bus.mem_ready),
        .expire_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and datapath decode; outputs are all registered off *_d.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ir_d      = ir_q;
        pc_next_d = pc_next_q;
        mem_req_d = 1'b0;
        done_d    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d   = ST_REQ;
                    addr_d    = bus.pc_in;
                    mem_req_d = 1'b1;
                end
            end
            ST_REQ: begin
                // Ready wins over a timeout landing on the same cycle.
                if (bus.mem_ready) begin
                    ir_d      = bus.mem_rdata;
                    pc_next_d = addr_q + ADDR_W'(INSTR_BYTES);
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (timeout_hit) begin
`ifdef FETCH_TIMEOUT_EN
                    err_d     = 1'b1;
                    state_d   = ST_ERR;
`endif
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
`ifdef FETCH_TIMEOUT_EN
            ST_ERR:  state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset clears every visible output immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            ir_q      <= '0;
            pc_next_q <= '0;
            mem_req_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ir_q      <= ir_d;
            pc_next_q <= pc_next_d;
            mem_req_q <= mem_req_d;
            done_q    <= done_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Timeout pulse register, high for the single ERR cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end
    assign bus.fetch_err = err_q;
`else
    assign bus.fetch_err = 1'b0;
`endif

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.ir_out     = ir_q;
    assign bus.pc_next    = pc_next_q;
    assign bus.pc_write   = done_q;
    assign bus.fetch_done = done_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table of fetches plus
// hand sequences for held fetch_start, mid-REQ reset and (with
// FETCH_TIMEOUT_EN) the timeout/ready-wins cases.
module tb_instruction_fetch_unit;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pw_cnt   = 0;
    int   fd_cnt   = 0;
    int   err_cnt  = 0;
    logic [31:0] last_ir = '0;

    instruction_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instruction_fetch_unit #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.pc_write)   pw_cnt++;
        if (bus.fetch_done) fd_cnt++;
        if (bus.fetch_err)  err_cnt++;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          wait_cyc;
        logic [31:0] exp_ir;
        logic [31:0] exp_pc_next;
    } fetch_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete fetch with `wait_cyc` unanswered REQ cycles before ready.
    task automatic do_fetch(input fetch_vec_t v);
        int pw0, fd0;
        pw0 = pw_cnt;
        fd0 = fd_cnt;
        bus.pc_in       = v.pc;
        bus.fetch_start = 1'b1;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = 32'hBAD0_0BAD;
        tick();
        bus.fetch_start = 1'b0;
        bus.pc_in       = ~v.pc;   // address must come from the latch, not pc_in
        for (int w = 0; w <= v.wait_cyc; w++) begin
            chk("req_mem_req", bus.mem_req, 1);
            chk("req_mem_addr", bus.mem_addr, v.pc);
            chk("req_no_pc_write", bus.pc_write, 0);
            chk("req_busy", bus.busy, 1);
            if (w == v.wait_cyc) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = v.rdata;
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        chk("done_pc_write", bus.pc_write, 1);
        chk("done_fetch_done", bus.fetch_done, 1);
        chk("done_ir_out", bus.ir_out, v.exp_ir);
        chk("done_pc_next", bus.pc_next, v.exp_pc_next);
        chk("done_mem_req", bus.mem_req, 0);
        chk("done_busy", bus.busy, 1);
        tick();
        chk("idle_pc_write", bus.pc_write, 0);
        chk("idle_fetch_done", bus.fetch_done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_ir_hold", bus.ir_out, v.exp_ir);
        chk("pc_write_pulses", pw_cnt - pw0, 1);
        chk("fetch_done_pulses", fd_cnt - fd0, 1);
        last_ir = v.exp_ir;
    endtask

    fetch_vec_t vecs[5];

    initial begin
        int pw0;
        vecs[0] = '{32'h0040_0000, 32'h8C08_0004, 0, 32'h8C08_0004, 32'h0040_0004};
        vecs[1] = '{32'h0040_0004, 32'h2108_FFFF, 5, 32'h2108_FFFF, 32'h0040_0008};
        vecs[2] = '{32'hFFFF_FFFC, 32'h0810_0000, 1, 32'h0810_0000, 32'h0000_0000};
        vecs[3] = '{32'h1234_5679, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 32'h1234_567D};
        vecs[4] = '{32'h7FFF_FFFC, 32'h0000_0000, 0, 32'h0000_0000, 32'h8000_0000};

        bus.fetch_start = 1'b0;
        bus.pc_in       = '0;
        bus.mem_rdata   = '0;
        bus.mem_ready   = 1'b0;

        // Reset state
        #2;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_ir_out", bus.ir_out, 0);
        chk("rst_pc_next", bus.pc_next, 0);
        chk("rst_pc_write", bus.pc_write, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fetch_err", bus.fetch_err, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Table of fetches, applied back to back
        for (int i = 0; i < 5; i++) do_fetch(vecs[i]);

        // fetch_start held through REQ and DONE: one fetch per IDLE acceptance
        pw0 = pw_cnt;
        bus.pc_in       = 32'h0000_0100;
        bus.fetch_start = 1'b1;
        tick();
        bus.pc_in = 32'h0000_0200;
        chk("hold_addr1", bus.mem_addr, 32'h0000_0100);
        chk("hold_busy_req", bus.busy, 1);
        tick();
        chk("hold_still_req", bus.mem_req, 1);
        chk("hold_addr1_stable", bus.mem_addr, 32'h0000_0100);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h2002_000A;
        tick();
        bus.mem_ready = 1'b0;
        chk("hold_done_busy", bus.busy, 1);
        chk("hold_done_mem_req", bus.mem_req, 0);
        chk("hold_done_pc_next", bus.pc_next, 32'h0000_0104);
        tick();
        chk("hold_idle_busy", bus.busy, 0);
        chk("hold_idle_mem_req", bus.mem_req, 0);
        tick();
        chk("hold_reaccept_req", bus.mem_req, 1);
        chk("hold_reaccept_addr", bus.mem_addr, 32'h0000_0200);
        bus.fetch_start = 1'b0;
        bus.mem_ready   = 1'b1;
        bus.mem_rdata   = 32'h0000_0020;
        tick();
        bus.mem_ready = 1'b0;
        chk("hold2_pc_next", bus.pc_next, 32'h0000_0204);
        tick();
        chk("hold_total_pulses", pw_cnt - pw0, 2);
        last_ir = 32'h0000_0020;

        // Reset asserted mid-REQ clears outputs without a clock edge
        bus.pc_in       = 32'h0000_0300;
        bus.fetch_start = 1'b1;
        tick();
        bus.fetch_start = 1'b0;
        tick();
        chk("pre_rst_mem_req", bus.mem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_mem_req", bus.mem_req, 0);
        chk("async_ir_out", bus.ir_out, 0);
        chk("async_pc_next", bus.pc_next, 0);
        chk("async_mem_addr", bus.mem_addr, 0);
        chk("async_busy", bus.busy, 0);
        tick();
        reset_n = 1'b1;
        pw0 = pw_cnt;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_mem_req", bus.mem_req, 0);
        chk("post_rst_no_pulse", pw_cnt - pw0, 0);
        last_ir = '0;

`ifdef FETCH_TIMEOUT_EN
        // Seed the IR, then let memory never answer
        do_fetch(vecs[0]);
        pw0 = pw_cnt;
        bus.pc_in       = 32'h0000_0500;
        bus.fetch_start = 1'b1;
        tick();
        bus.fetch_start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("to_wait_req", bus.mem_req, 1);
            chk("to_wait_err", bus.fetch_err, 0);
        end
        tick();
        chk("to_err_pulse", bus.fetch_err, 1);
        chk("to_err_mem_req", bus.mem_req, 0);
        chk("to_err_pc_write", bus.pc_write, 0);
        chk("to_err_ir_hold", bus.ir_out, last_ir);
        chk("to_err_busy", bus.busy, 1);
        tick();
        chk("to_idle_err", bus.fetch_err, 0);
        chk("to_idle_busy", bus.busy, 0);
        chk("to_no_pc_write", pw_cnt - pw0, 0);
        chk("to_err_count", err_cnt, 1);
        // Ready on the 4th wait cycle: success, not timeout
        do_fetch('{32'h0000_0600, 32'h1000_FFFF, 3, 32'h1000_FFFF, 32'h0000_0604});
        chk("to_ready_wins", err_cnt, 1);
`else
        chk("no_timeout_err", err_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
